speculation_checkpoint: RTL and testbench

Speculation-support block for the 5-stage MIPS core's hazard controller. It has three parts:
- a branch controller that predicts conditional branches at decode and trains on execute results;
- a 32-entry architectural register snapshot used for value-prediction rollback;
- a holding register for one pending D-cache request.

Training is frozen while a value prediction is outstanding (`vp_lock`).

---
 rtl/mips_core_pkg.sv | 42 ++++
 rtl/bht_predictor.sv | 54 +++++
 rtl/speculation_checkpoint.sv | 121 ++++++++++++
 tb/tb_speculation_checkpoint.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// mips_core_pkg
// Shared types for the 5-stage MIPS core speculation logic.
//   DATA_WIDTH        : width of data words, addresses and PCs
//   branch_outcome_t  : NOT_TAKEN / TAKEN
//   mem_access_type_t : READ / WRITE
//   d_cache_req_t     : one D-cache request {valid, mem_action, addr, addr_next, data}
//   bht_step()        : one saturating step of a 2-bit branch counter
package mips_core_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } branch_outcome_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_access_type_t;

    typedef struct packed {
        logic                  valid;
        mem_access_type_t      mem_action;
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] addr_next;
        logic [DATA_WIDTH-1:0] data;
    } d_cache_req_t;

    // Move a 2-bit counter one step toward the outcome, saturating at 00/11.
    function automatic logic [1:0] bht_step(input logic [1:0] cnt, input branch_outcome_t outcome);
        logic [1:0] result;
        result = cnt;
        if (outcome == TAKEN) begin
            if (cnt != 2'b11) result = cnt + 2'b01;
        end else begin
            if (cnt != 2'b00) result = cnt - 2'b01;
        end
        return result;
    endfunction

endpackage

// File: rtl/bht_predictor.sv
// bht_predictor
// Table of 2^BHT_BITS two-bit saturating counters with one combinational
// read port (prediction) and one synchronous write port (training).
//   clk, rst_n  : clock, asynchronous active-low reset (counters -> 01)
//   rd_idx      : index of the branch being predicted
//   rd_taken    : MSB of the selected counter (1 = predict taken)
//   wr_en       : apply one training step this edge
//   wr_idx      : index of the resolved branch
//   wr_outcome  : actual outcome of the resolved branch
module bht_predictor
    import mips_core_pkg::*;
#(
    parameter int BHT_BITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BHT_BITS-1:0] rd_idx,
    output logic                rd_taken,
    input  logic                wr_en,
    input  logic [BHT_BITS-1:0] wr_idx,
    input  branch_outcome_t     wr_outcome
);

    localparam int ENTRIES = 1 << BHT_BITS;

    logic [1:0]         counter_reg [ENTRIES];
    logic [ENTRIES-1:0] wr_sel;

    // One-hot decode of the training index.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_sel
            assign wr_sel[gi] = wr_en && (wr_idx == BHT_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counter_reg[i] <= 2'b01;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (wr_sel[i]) begin
                    counter_reg[i] <= bht_step(counter_reg[i], wr_outcome);
                end
            end
        end
    end

    // Reads the pre-update value, so a same-cycle predict/train of one
    // index sees the old counter.
    assign rd_taken = counter_reg[rd_idx][1];

endmodule

// File: rtl/speculation_checkpoint.sv
// speculation_checkpoint
// Speculation support for the MIPS hazard controller:
//   - branch prediction at decode, trained from execute (frozen by vp_lock)
//   - architectural register snapshot for value-prediction rollback
//   - holding register for one pending D-cache request
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   dec_pc/branch_valid/is_jump/target : decoded branch
//   dec_prediction, dec_recovery_target: prediction and fallback fetch PC
//   ex_branch_valid/pc/prediction/outcome : resolved branch for training
//   vp_lock                            : freeze training
//   take_snapshot, regs_in             : capture the register file
//   regs_snapshot, snap_done           : saved registers, capture confirm
//   req_capture, req_in_*              : latch an incoming D-cache request
//   req_out_*                          : held D-cache request
module speculation_checkpoint
    import mips_core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int BHT_BITS   = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          dec_pc,
    input  logic                           dec_branch_valid,
    input  logic                           dec_is_jump,
    input  logic [DATA_WIDTH-1:0]          dec_target,
    output logic                           dec_prediction,
    output logic [DATA_WIDTH-1:0]          dec_recovery_target,
    input  logic                           ex_branch_valid,
    input  logic [DATA_WIDTH-1:0]          ex_pc,
    input  logic                           ex_prediction,
    input  logic                           ex_outcome,
    input  logic                           vp_lock,
    input  logic                           take_snapshot,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_snapshot,
    output logic                           snap_done,
    input  logic                           req_capture,
    input  logic                           req_in_valid,
    input  logic                           req_in_action,
    input  logic [DATA_WIDTH-1:0]          req_in_addr,
    input  logic [DATA_WIDTH-1:0]          req_in_addr_next,
    input  logic [DATA_WIDTH-1:0]          req_in_data,
    output logic                           req_out_valid,
    output logic                           req_out_action,
    output logic [DATA_WIDTH-1:0]          req_out_addr,
    output logic [DATA_WIDTH-1:0]          req_out_addr_next,
    output logic [DATA_WIDTH-1:0]          req_out_data
);

    // ---------------- branch prediction ----------------
    logic bht_taken;

    bht_predictor #(
        .BHT_BITS(BHT_BITS)
    ) u_bht (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx     (dec_pc[BHT_BITS+1:2]),
        .rd_taken   (bht_taken),
        .wr_en      (ex_branch_valid && !vp_lock),
        .wr_idx     (ex_pc[BHT_BITS+1:2]),
        .wr_outcome (branch_outcome_t'(ex_outcome))
    );

    assign dec_prediction = dec_branch_valid && (dec_is_jump || bht_taken);

    // Taken prediction: the fallback is the fall-through past the delay slot.
    assign dec_recovery_target = dec_prediction ? (dec_pc + DATA_WIDTH'(8)) : dec_target;

    // ex_prediction only feeds external statistics; the PC bits outside the
    // index do not select a counter.
    logic unused_bits;
    assign unused_bits = ^{ex_prediction, ex_pc};

    // ---------------- register snapshot ----------------
    logic [NUM_REGS*DATA_WIDTH-1:0] snapshot_reg;
    logic                           snap_done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot_reg  <= '0;
            snap_done_reg <= 1'b0;
        end else begin
            snap_done_reg <= take_snapshot;
            if (take_snapshot) begin
                snapshot_reg <= regs_in;
            end
        end
    end

    assign regs_snapshot = snapshot_reg;
    assign snap_done     = snap_done_reg;

    // ---------------- D-cache request hold ----------------
    d_cache_req_t req_in_pkt;
    d_cache_req_t req_reg;

    assign req_in_pkt.valid      = req_in_valid;
    assign req_in_pkt.mem_action = mem_access_type_t'(req_in_action);
    assign req_in_pkt.addr       = req_in_addr;
    assign req_in_pkt.addr_next  = req_in_addr_next;
    assign req_in_pkt.data       = req_in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_reg <= '0;
        end else if (req_capture) begin
            req_reg <= req_in_pkt;
        end
    end

    assign req_out_valid     = req_reg.valid;
    assign req_out_action    = req_reg.mem_action;
    assign req_out_addr      = req_reg.addr;
    assign req_out_addr_next = req_reg.addr_next;
    assign req_out_data      = req_reg.data;

endmodule

// File: tb/tb_speculation_checkpoint.sv
module tb_speculation_checkpoint;

    localparam int DW = 32;
    localparam int NR = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  dec_pc = '0;
    logic           dec_branch_valid = 1'b0;
    logic           dec_is_jump = 1'b0;
    logic [DW-1:0]  dec_target = '0;
    logic           dec_prediction;
    logic [DW-1:0]  dec_recovery_target;
    logic           ex_branch_valid = 1'b0;
    logic [DW-1:0]  ex_pc = '0;
    logic           ex_prediction = 1'b0;
    logic           ex_outcome = 1'b0;
    logic           vp_lock = 1'b0;
    logic           take_snapshot = 1'b0;
    logic [NR*DW-1:0] regs_in = '0;
    logic [NR*DW-1:0] regs_snapshot;
    logic           snap_done;
    logic           req_capture = 1'b0;
    logic           req_in_valid = 1'b0;
    logic           req_in_action = 1'b0;
    logic [DW-1:0]  req_in_addr = '0;
    logic [DW-1:0]  req_in_addr_next = '0;
    logic [DW-1:0]  req_in_data = '0;
    logic           req_out_valid;
    logic           req_out_action;
    logic [DW-1:0]  req_out_addr;
    logic [DW-1:0]  req_out_addr_next;
    logic [DW-1:0]  req_out_data;

    int n_checks = 0;
    int n_fail   = 0;

    speculation_checkpoint #(.DATA_WIDTH(DW), .NUM_REGS(NR), .BHT_BITS(6)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .dec_pc              (dec_pc),
        .dec_branch_valid    (dec_branch_valid),
        .dec_is_jump         (dec_is_jump),
        .dec_target          (dec_target),
        .dec_prediction      (dec_prediction),
        .dec_recovery_target (dec_recovery_target),
        .ex_branch_valid     (ex_branch_valid),
        .ex_pc               (ex_pc),
        .ex_prediction       (ex_prediction),
        .ex_outcome          (ex_outcome),
        .vp_lock             (vp_lock),
        .take_snapshot       (take_snapshot),
        .regs_in             (regs_in),
        .regs_snapshot       (regs_snapshot),
        .snap_done           (snap_done),
        .req_capture         (req_capture),
        .req_in_valid        (req_in_valid),
        .req_in_action       (req_in_action),
        .req_in_addr         (req_in_addr),
        .req_in_addr_next    (req_in_addr_next),
        .req_in_data         (req_in_data),
        .req_out_valid       (req_out_valid),
        .req_out_action      (req_out_action),
        .req_out_addr        (req_out_addr),
        .req_out_addr_next   (req_out_addr_next),
        .req_out_data        (req_out_data)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Set the decode inputs and check the combinational prediction.
    task automatic check_pred(input string name, input logic [DW-1:0] pc, input logic valid,
                              input logic jump, input logic [DW-1:0] tgt,
                              input logic exp_pred, input logic [DW-1:0] exp_rec);
        dec_pc = pc;
        dec_branch_valid = valid;
        dec_is_jump = jump;
        dec_target = tgt;
        #1;
        n_checks++;
        if (dec_prediction !== exp_pred || dec_recovery_target !== exp_rec) begin
            n_fail++;
            $display("FAIL %s: pred=%0b rec=0x%08h, required pred=%0b rec=0x%08h",
                     name, dec_prediction, dec_recovery_target, exp_pred, exp_rec);
        end else begin
            $display("ok   %s: pred=%0b rec=0x%08h", name, dec_prediction, dec_recovery_target);
        end
    endtask

    task automatic train(input logic [DW-1:0] pc, input logic outcome, input int times);
        for (int i = 0; i < times; i++) begin
            ex_branch_valid = 1'b1;
            ex_pc = pc;
            ex_outcome = outcome;
            ex_prediction = ~outcome;
            step();
        end
        ex_branch_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_pred("reset_pred_0x40", 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h100);
        n_checks++;
        if (snap_done !== 1'b0 || regs_snapshot !== '0) begin
            n_fail++;
            $display("FAIL reset_snapshot: snap_done=%0b snapshot_nonzero=%0b, required 0/0",
                     snap_done, |regs_snapshot);
        end else $display("ok   reset_snapshot");
        n_checks++;
        if ({req_out_valid, req_out_action, req_out_addr, req_out_addr_next, req_out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_req: valid=%0b addr=0x%08h data=0x%08h, required all 0",
                     req_out_valid, req_out_addr, req_out_data);
        end else $display("ok   reset_req");
    endtask

    task automatic test_training();
        train(32'h40, 1'b1, 2);                                   // 01 -> 11
        check_pred("train_tt", 32'h40, 1'b1, 1'b0, 32'h100, 1'b1, 32'h48);
        train(32'h40, 1'b1, 1);                                   // saturate at 11
        check_pred("train_sat_hi", 32'h40, 1'b1, 1'b0, 32'h100, 1'b1, 32'h48);
        train(32'h40, 1'b0, 1);                                   // 10
        check_pred("train_nt1", 32'h40, 1'b1, 1'b0, 32'h100, 1'b1, 32'h48);
        train(32'h40, 1'b0, 1);                                   // 01
        check_pred("train_nt2", 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h100);
        train(32'h40, 1'b0, 3);                                   // saturate at 00
        train(32'h40, 1'b1, 1);                                   // 01
        check_pred("train_sat_lo", 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h100);
        train(32'h40, 1'b1, 1);                                   // 10
        check_pred("train_from_lo", 32'h40, 1'b1, 1'b0, 32'h100, 1'b1, 32'h48);
        train(32'h40, 1'b0, 1);                                   // back to 01
    endtask

    task automatic test_vp_lock();
        vp_lock = 1'b1;
        train(32'h40, 1'b1, 3);
        check_pred("vp_locked", 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h100);
        vp_lock = 1'b0;
        train(32'h40, 1'b1, 1);                                   // 10
        check_pred("vp_released", 32'h40, 1'b1, 1'b0, 32'h100, 1'b1, 32'h48);
    endtask

    task automatic test_same_cycle();
        // Counter(0x40)=10. Train not-taken while predicting the same index.
        dec_pc = 32'h40; dec_branch_valid = 1'b1; dec_is_jump = 1'b0; dec_target = 32'h100;
        ex_branch_valid = 1'b1; ex_pc = 32'h40; ex_outcome = 1'b0;
        #1;
        n_checks++;
        if (dec_prediction !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_pre: pred=%0b, required 1", dec_prediction);
        end else $display("ok   same_cycle_pre");
        step();
        ex_branch_valid = 1'b0;
        check_pred("same_cycle_post", 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h100);
        // Index separation and aliasing: 0x44 is its own entry, 0x140 aliases 0x40.
        train(32'h44, 1'b1, 1);
        check_pred("idx_0x44", 32'h44, 1'b1, 1'b0, 32'h300, 1'b1, 32'h4C);
        check_pred("idx_0x40_kept", 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h100);
        train(32'h140, 1'b1, 2);
        check_pred("alias_0x40", 32'h40, 1'b1, 1'b0, 32'h100, 1'b1, 32'h48);
    endtask

    task automatic test_jump();
        check_pred("jump_0x200", 32'h200, 1'b1, 1'b1, 32'h500, 1'b1, 32'h208);
        check_pred("jump_wrap", 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h500, 1'b1, 32'h0000_0004);
        check_pred("no_valid", 32'h200, 1'b0, 1'b1, 32'h500, 1'b0, 32'h500);
        step();
        check_pred("bht_0x200_kept", 32'h200, 1'b1, 1'b0, 32'h500, 1'b0, 32'h500);
    endtask

    task automatic test_snapshot();
        for (int i = 0; i < NR; i++) regs_in[i*DW +: DW] = DW'(i * 3);
        take_snapshot = 1'b1;
        step();
        take_snapshot = 1'b0;
        n_checks++;
        if (regs_snapshot[31*DW +: DW] !== 32'd93 || regs_snapshot[5*DW +: DW] !== 32'd15 ||
            regs_snapshot[0 +: DW] !== 32'd0 || snap_done !== 1'b1) begin
            n_fail++;
            $display("FAIL snap_capture: r31=%0d r5=%0d r0=%0d done=%0b, required 93/15/0/1",
                     regs_snapshot[31*DW +: DW], regs_snapshot[5*DW +: DW],
                     regs_snapshot[0 +: DW], snap_done);
        end else $display("ok   snap_capture: r31=%0d", regs_snapshot[31*DW +: DW]);
        for (int i = 0; i < NR; i++) regs_in[i*DW +: DW] = DW'(1000 + i);
        step();
        n_checks++;
        if (snap_done !== 1'b0 || regs_snapshot[31*DW +: DW] !== 32'd93) begin
            n_fail++;
            $display("FAIL snap_hold: r31=%0d done=%0b, required 93/0",
                     regs_snapshot[31*DW +: DW], snap_done);
        end else $display("ok   snap_hold");
        // Held high: capture every cycle, snap_done stays high.
        take_snapshot = 1'b1;
        step();
        regs_in[31*DW +: DW] = 32'd77;
        step();
        take_snapshot = 1'b0;
        n_checks++;
        if (snap_done !== 1'b1 || regs_snapshot[31*DW +: DW] !== 32'd77 ||
            regs_snapshot[2*DW +: DW] !== 32'd1002) begin
            n_fail++;
            $display("FAIL snap_held: r31=%0d r2=%0d done=%0b, required 77/1002/1",
                     regs_snapshot[31*DW +: DW], regs_snapshot[2*DW +: DW], snap_done);
        end else $display("ok   snap_held");
        step();
    endtask

    task automatic test_request();
        req_in_valid = 1'b1; req_in_action = 1'b0;
        req_in_addr = 32'h1000; req_in_addr_next = 32'h1004; req_in_data = 32'hDEAD;
        req_capture = 1'b1;
        take_snapshot = 1'b1;   // both captures in the same cycle
        step();
        req_capture = 1'b0;
        take_snapshot = 1'b0;
        n_checks++;
        if (req_out_valid !== 1'b1 || req_out_action !== 1'b0 || req_out_addr !== 32'h1000 ||
            req_out_addr_next !== 32'h1004 || req_out_data !== 32'hDEAD || snap_done !== 1'b1) begin
            n_fail++;
            $display("FAIL req_capture: v=%0b a=%0b addr=0x%08h next=0x%08h data=0x%08h done=%0b, required 1/0/0x1000/0x1004/0xdead/1",
                     req_out_valid, req_out_action, req_out_addr, req_out_addr_next, req_out_data, snap_done);
        end else $display("ok   req_capture");
        req_in_valid = 1'b0; req_in_action = 1'b1;
        req_in_addr = 32'h2000; req_in_addr_next = 32'h3000; req_in_data = 32'hBEEF;
        step();
        step();
        n_checks++;
        if (req_out_valid !== 1'b1 || req_out_action !== 1'b0 || req_out_addr !== 32'h1000 ||
            req_out_addr_next !== 32'h1004 || req_out_data !== 32'hDEAD) begin
            n_fail++;
            $display("FAIL req_hold: v=%0b a=%0b addr=0x%08h next=0x%08h data=0x%08h, required unchanged",
                     req_out_valid, req_out_action, req_out_addr, req_out_addr_next, req_out_data);
        end else $display("ok   req_hold");
        // Second capture: WRITE with addr_next not derived from addr.
        req_in_valid = 1'b1;
        req_capture = 1'b1;
        take_snapshot = 1'b1;
        step();
        req_capture = 1'b0;
        n_checks++;
        if (req_out_action !== 1'b1 || req_out_addr_next !== 32'h3000 || req_out_data !== 32'hBEEF) begin
            n_fail++;
            $display("FAIL req_write: a=%0b next=0x%08h data=0x%08h, required 1/0x3000/0xbeef",
                     req_out_action, req_out_addr_next, req_out_data);
        end else $display("ok   req_write");
        // Asynchronous reset mid-cycle, with a capture pending.
        req_capture = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_out_valid, req_out_action, req_out_addr, req_out_addr_next, req_out_data} !== '0 ||
            snap_done !== 1'b0 || regs_snapshot !== '0) begin
            n_fail++;
            $display("FAIL async_reset: v=%0b addr=0x%08h done=%0b snap_nonzero=%0b, required all 0",
                     req_out_valid, req_out_addr, snap_done, |regs_snapshot);
        end else $display("ok   async_reset");
        step();
        n_checks++;
        if (req_out_valid !== 1'b0 || snap_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_overrides: v=%0b done=%0b, required 0/0", req_out_valid, snap_done);
        end else $display("ok   reset_overrides");
        req_capture = 1'b0;
        take_snapshot = 1'b0;
        check_pred("reset_bht_0x40", 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h100);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_training();
        test_vp_lock();
        test_same_cycle();
        test_jump();
        test_snapshot();
        test_request();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
